mips_multicycle_core: RTL and testbench
=======================================

Name: mips_multicycle_core

Overview:
- 32-bit MIPS multicycle processor core (Harris & Harris style).
- Uses one unified memory port for both instruction fetch and data access.
- Sits between the top-level clock/reset and a single-port view of the dual-port instruction/data memory.
- Each instruction takes 3–5 cycles, sequenced by a main control FSM.

Parameters:
- N, 32, datapath/word width (fixed at 32; other values unsupported).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- read_data  input  32  word returned by memory for write_addr; combinational (valid in the same cycle).
- write_data  output  32  store data (rt register value) presented to memory.
- write_addr  output  32  byte address for both fetch and load/store; memory uses bits [11:2] as the word index, bits [1:0] ignored.
- MemWrite  output  1  memory write enable; memory writes write_data at write_addr on the rising edge when high.

Behaviour:
- Reset: when rst=1 at a clock edge, all of the following are set:
  - PC=RESET_PC, FSM=FETCH.
  - IR, MDR, A, B and ALUOut cleared to 0.
  - All 32 registers cleared to 0.
- During reset: MemWrite=0, write_addr=PC, write_data=0.
- Reset asserted mid-instruction aborts that instruction; no partial register or memory write occurs on that edge.
- Address mux: write_addr=PC in FETCH, ALUOut in MEMREAD/MEMWRITE, PC otherwise.
- ISA supported: lw, sw, beq, addi, j, and R-type add, sub, and, or, slt.
- Any other opcode/funct is treated as a NOP: the FSM returns to FETCH after DECODE and no state changes except PC+4.
- FSM states and transitions:
  - FETCH: IR<=read_data; PC<=PC+4. Next state DECODE.
  - DECODE: A<=rs, B<=rt; ALUOut<=PC+(signext(imm)<<2). Next state is chosen by opcode.
  - MEMADR (lw/sw): ALUOut<=A+signext(imm). Next state MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: MDR<=read_data. Next state MEMWB.
  - MEMWB: rt<=MDR. Next state FETCH.
  - MEMWRITE: MemWrite=1 for exactly this cycle; write_data=B. Next state FETCH.
  - EXECUTE (R-type): ALUOut<=A op B. Next state ALUWB.
  - ALUWB: rd<=ALUOut. Next state FETCH.
  - BEQEX: if A==B then PC<=ALUOut. Next state FETCH.
  - ADDIEX: ALUOut<=A+signext(imm). Next state ADDIWB.
  - ADDIWB: rt<=ALUOut. Next state FETCH.
  - JEX: PC<={PC[31:28], addr26, 2'b00}. Next state FETCH.
- Instruction latency in cycles: lw 5; sw, R-type and addi 4; beq and j 3.
- Arithmetic: all operations are 32-bit two's complement.
  - Overflow wraps; no exceptions are raised.
  - slt is a signed compare producing 1 or 0.
  - The immediate is sign-extended.
- Register $0 reads as 0; writes to it are ignored.
- Register file: 2 combinational read ports, 1 synchronous write port.
- Branch target is computed from PC+4, so offset 0 falls through and offset -1 loops on itself.
- Memory map (synth_dual_port_memory, 1024 words):
  - Code is loaded at word 0.
  - A data array DMEM[0..1023] is also word-addressed; load/store address byte 4k maps to DMEM[k].
- Out-of-range addresses wrap modulo 4 KiB.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (RTYPE=6'h00, LW=6'h23, SW=6'h2B, BEQ=6'h04, ADDI=6'h08, J=6'h02);
  - funct constants (ADD=6'h20, SUB=6'h22, AND=6'h24, OR=6'h25, SLT=6'h2A);
  - the FSM state enum;
  - 3-bit ALU control codes.
- One natural sub-module: mips_regfile (32x32, 2R/1W, synchronous write, synchronous clear on rst).
- The ALU and control FSM stay inline in the core.

Test Plan:
- Reset: hold rst=1 for 2 cycles → MemWrite=0, write_addr=0. After release, first fetch is at address 0 and the second fetch is at address 4 exactly 3+ cycles later.
- ALU and store: program addi $2,$0,5; addi $3,$0,12; add $4,$2,$3; sub $5,$3,$2; sw $4,0($0); sw $5,4($0) → DMEM[0]=0x11, DMEM[1]=0x7. MemWrite is high for exactly one cycle per sw.
- Logic, slt and lw: and, or, slt $6,$3,$2 with values 12 and 5, stored to DMEM[2..4]; then lw $7,8($0) and sw $7,20($0) → DMEM[2]=0x4, DMEM[3]=0xD, DMEM[4]=0x0, DMEM[5]=0x4.
- Branches and jump:
  - beq $2,$2,+1 skips the next addi; a not-taken beq falls through.
  - j jumps to a target that stores 0xABCD to DMEM[10].
  - The skipped instruction's marker store must not appear.
- Register $0 and negative values: addi $0,$0,7 then sw $0,24($0) → DMEM[6]=0. addi $8,$0,-1 stored → 0xFFFFFFFF.
- Reset mid-run: assert rst during a MEMWRITE-bound sw → no write to memory; PC restarts at 0 and the program re-executes with identical results.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : opcodes, functs, FSM states and ALU helpers for the MIPS core
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQEX    = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JEX      = 4'd11
  } state_e;

  function automatic logic funct_supported(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic alu_ctrl_e funct_alu(input logic [5:0] fn);
    alu_ctrl_e ctrl;
    case (fn)
      FN_SUB:  ctrl = ALU_SUB;
      FN_AND:  ctrl = ALU_AND;
      FN_OR:   ctrl = ALU_OR;
      FN_SLT:  ctrl = ALU_SLT;
      default: ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

  function automatic logic [31:0] alu_op(input alu_ctrl_e ctrl,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] y;
    case (ctrl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: y = a + b;
    endcase
    return y;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_regfile.sv
// ============================================================================
// mips_regfile : 32x32 register file, 2 async read / 1 sync write, $0 fixed 0
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mips_regfile #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   ra1_i,
  input  logic [4:0]   ra2_i,
  input  logic         we_i,
  input  logic [4:0]   wa_i,
  input  logic [N-1:0] wd_i,
  output logic [N-1:0] rd1_o,
  output logic [N-1:0] rd2_o
);

  logic [N-1:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_core.sv
// ============================================================================
// mips_multicycle_core : Harris & Harris style multicycle MIPS, unified memory
// Revision             : 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int unsigned    N        = 32,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] read_data,
  output logic [N-1:0] write_data,
  output logic [N-1:0] write_addr,
  output logic         MemWrite
);

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, ir_q, mdr_q, a_q, b_q, aluout_q;
  logic         memwrite_q;

  logic [5:0]   opcode, funct;
  logic [4:0]   rs, rt, rd;
  logic [N-1:0] imm_sext;
  logic [N-1:0] rf_rd1, rf_rd2, rf_wdata;
  logic [4:0]   rf_waddr;
  logic         rf_we;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{(N-16){ir_q[15]}}, ir_q[15:0]};

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_supported(funct) ? S_EXECUTE : S_FETCH;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      mdr_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      aluout_q   <= '0;
      memwrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      memwrite_q <= (state_d == S_MEMWRITE);
      case (state_q)
        S_FETCH: begin
          ir_q <= read_data;
          pc_q <= pc_q + N'(4);
        end
        S_DECODE: begin
          a_q      <= rf_rd1;
          b_q      <= rf_rd2;
          aluout_q <= pc_q + (imm_sext << 2);
        end
        S_MEMADR, S_ADDIEX: aluout_q <= a_q + imm_sext;
        S_MEMREAD:          mdr_q    <= read_data;
        S_EXECUTE:          aluout_q <= alu_op(funct_alu(funct), a_q, b_q);
        S_BEQEX:            if (a_q == b_q) pc_q <= aluout_q;
        S_JEX:              pc_q <= {pc_q[N-1:N-4], ir_q[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  // Write-back sources; the register file's own clear wins while rst is high.
  assign rf_we    = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_ADDIWB);
  assign rf_waddr = (state_q == S_ALUWB) ? rd : rt;
  assign rf_wdata = (state_q == S_MEMWB) ? mdr_q : aluout_q;

  mips_regfile #(.N(N)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (rs),
    .ra2_i (rt),
    .we_i  (rf_we),
    .wa_i  (rf_waddr),
    .wd_i  (rf_wdata),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2)
  );

  // Gating with rst keeps an aborted store from reaching memory on the reset edge.
  assign MemWrite   = memwrite_q & ~rst;
  assign write_data = rst ? '0 : b_q;
  assign write_addr = (!rst && (state_q == S_MEMREAD || state_q == S_MEMWRITE))
                      ? aluout_q : pc_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_core.sv
// ============================================================================
// tb_mips_multicycle_core : directed + random programs against an ISA model
// Revision                : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mips_multicycle_core;

  localparam int MAXC = 1024;
  localparam int DBASE = 512;
  localparam logic [31:0] HALT = 32'h1000FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0;
  logic [31:0] read_data, write_data, write_addr;
  logic        MemWrite;

  logic [31:0] mem    [0:1023];
  logic [31:0] image  [0:1023];
  logic [31:0] mem_m  [0:1023];
  int          exp_kind [MAXC];
  logic [31:0] exp_addr [MAXC];
  logic [31:0] exp_data [MAXC];
  int          last_cycle;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_core #(.N(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .read_data  (read_data),
    .write_data (write_data),
    .write_addr (write_addr),
    .MemWrite   (MemWrite)
  );

  assign read_data = mem[write_addr[11:2]];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= image[i];
    end else if (MemWrite) begin
      mem[write_addr[11:2]] <= write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input int target_word);
    return {6'h02, 26'(target_word)};
  endfunction

  // Instruction-level reference: per instruction, which cycle offsets touch memory.
  task automatic build_model();
    logic [31:0] r [32];
    logic [31:0] pc, ins, va, vb, se, ea, res;
    int c;
    bit halt;
    for (int i = 0; i < 32; i++) r[i] = 0;
    for (int i = 0; i < 1024; i++) mem_m[i] = image[i];
    for (int i = 0; i < MAXC; i++) exp_kind[i] = 0;
    pc = 0; c = 0; halt = 0;
    while (!halt && c < MAXC - 8) begin
      ins = mem_m[pc[11:2]];
      exp_kind[c] = 1; exp_addr[c] = pc;
      if (ins == HALT) begin
        last_cycle = c;
        halt = 1;
      end else begin
        va = r[ins[25:21]];
        vb = r[ins[20:16]];
        se = {{16{ins[15]}}, ins[15:0]};
        pc = pc + 4;
        case (ins[31:26])
          6'h23: begin
            ea = va + se;
            exp_kind[c+3] = 2; exp_addr[c+3] = ea;
            r[ins[20:16]] = mem_m[ea[11:2]];
            c += 5;
          end
          6'h2B: begin
            ea = va + se;
            exp_kind[c+3] = 3; exp_addr[c+3] = ea; exp_data[c+3] = vb;
            mem_m[ea[11:2]] = vb;
            c += 4;
          end
          6'h00: begin
            case (ins[5:0])
              6'h20: begin res = va + vb; r[ins[15:11]] = res; c += 4; end
              6'h22: begin res = va - vb; r[ins[15:11]] = res; c += 4; end
              6'h24: begin res = va & vb; r[ins[15:11]] = res; c += 4; end
              6'h25: begin res = va | vb; r[ins[15:11]] = res; c += 4; end
              6'h2A: begin res = ($signed(va) < $signed(vb)) ? 1 : 0; r[ins[15:11]] = res; c += 4; end
              default: c += 2;
            endcase
          end
          6'h04: begin
            if (va == vb) pc = pc + (se << 2);
            c += 3;
          end
          6'h08: begin r[ins[20:16]] = va + se; c += 4; end
          6'h02: begin pc = {pc[31:28], ins[25:0], 2'b00}; c += 3; end
          default: c += 2;
        endcase
        r[0] = 0;
      end
    end
    if (!halt) last_cycle = c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
    #1;
    check("reset_memwrite", {31'd0, MemWrite}, 32'd0);
    check("reset_addr", write_addr, 32'h0);
    check("reset_wdata", write_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_program(input string name);
    do_reset();
    for (int k = 0; k <= last_cycle + 2; k++) begin
      #1;
      check($sformatf("%s_we@%0d", name, k), {31'd0, MemWrite}, {31'd0, exp_kind[k] == 3});
      if (exp_kind[k] != 0)
        check($sformatf("%s_addr@%0d", name, k), write_addr, exp_addr[k]);
      if (exp_kind[k] == 3)
        check($sformatf("%s_wdata@%0d", name, k), write_data, exp_data[k]);
      @(negedge clk);
    end
    for (int i = DBASE; i < DBASE + 64; i++)
      check($sformatf("%s_dmem[%0d]", name, i - DBASE), mem[i], mem_m[i]);
  endtask

  task automatic abort_test();
    int k;
    int idx;
    do_reset();
    k = 0;
    #1;
    while (!MemWrite && k < 200) begin
      @(negedge clk); #1; k++;
    end
    check("abort_store_seen", {31'd0, MemWrite}, 32'd1);
    idx = int'(write_addr[11:2]);
    rst = 1'b1;
    #1;
    check("abort_we_gated", {31'd0, MemWrite}, 32'd0);
    check("abort_wdata", write_data, 32'h0);
    @(posedge clk); #1;
    check("abort_no_write", mem[idx], image[idx]);
  endtask

  task automatic gen_directed();
    for (int i = 0; i < 1024; i++) image[i] = (i >= DBASE) ? (32'hA5A5_0000 + 32'(i)) : 32'h0;
    image[0]  = enc_i(6'h08, 0, 1, 16'h0800);
    image[1]  = enc_i(6'h08, 0, 2, 16'd5);
    image[2]  = enc_i(6'h08, 0, 3, 16'd12);
    image[3]  = enc_r(6'h20, 2, 3, 4);
    image[4]  = enc_r(6'h22, 3, 2, 5);
    image[5]  = enc_i(6'h2B, 1, 4, 16'd0);
    image[6]  = enc_i(6'h2B, 1, 5, 16'd4);
    image[7]  = enc_r(6'h24, 3, 2, 6);
    image[8]  = enc_i(6'h2B, 1, 6, 16'd8);
    image[9]  = enc_r(6'h25, 3, 2, 6);
    image[10] = enc_i(6'h2B, 1, 6, 16'd12);
    image[11] = enc_r(6'h2A, 3, 2, 6);
    image[12] = enc_i(6'h2B, 1, 6, 16'd16);
    image[13] = enc_i(6'h23, 1, 7, 16'd8);
    image[14] = enc_i(6'h2B, 1, 7, 16'd20);
    image[15] = enc_i(6'h08, 0, 0, 16'd7);
    image[16] = enc_i(6'h2B, 1, 0, 16'd24);
    image[17] = enc_i(6'h08, 0, 8, 16'hFFFF);
    image[18] = enc_i(6'h2B, 1, 8, 16'd28);
    image[19] = enc_i(6'h04, 2, 2, 16'd1);
    image[20] = enc_i(6'h2B, 1, 2, 16'd32);
    image[21] = enc_i(6'h04, 2, 3, 16'd1);
    image[22] = enc_i(6'h2B, 1, 3, 16'd36);
    image[23] = enc_j(26);
    image[24] = enc_i(6'h2B, 1, 2, 16'd40);
    image[25] = enc_i(6'h2B, 1, 2, 16'd44);
    image[26] = enc_i(6'h08, 0, 9, 16'h5000);
    image[27] = enc_i(6'h08, 9, 9, 16'h5BCD);
    image[28] = enc_i(6'h2B, 1, 9, 16'd40);
    image[29] = enc_i(6'h0D, 2, 2, 16'h00FF);
    image[30] = enc_i(6'h2B, 1, 2, 16'd48);
    image[31] = HALT;
  endtask

  task automatic gen_random(input int L);
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int i = 0; i < 1024; i++) image[i] = (i >= DBASE) ? $urandom : 32'h0;
    image[0] = enc_i(6'h08, 0, 1, 16'h0800);
    for (int i = 1; i < L; i++) begin
      int kind, ra, rb, rw, hi;
      kind = $urandom_range(0, 9);
      ra = $urandom_range(0, 9);
      rb = $urandom_range(0, 9);
      rw = $urandom_range(0, 9);
      if (rw == 1) rw = 0;
      case (kind)
        0, 1: image[i] = enc_i(6'h08, ra, rw, 16'($urandom));
        2, 3: image[i] = enc_r(fns[$urandom_range(0, 4)], ra, rb, rw);
        4:    image[i] = enc_i(6'h23, 1, rw, 16'($urandom_range(0, 63) * 4));
        5:    image[i] = enc_i(6'h2B, 1, rb, 16'($urandom_range(0, 63) * 4));
        6: begin
          hi = (L - 1 - i < 3) ? (L - 1 - i) : 3;
          if ($urandom_range(0, 1) == 1) rb = ra;
          image[i] = enc_i(6'h04, ra, rb, 16'($urandom_range(0, hi)));
        end
        7:    image[i] = enc_j($urandom_range(i + 1, L));
        8:    image[i] = enc_r(6'h27, ra, rb, rw);
        default: image[i] = enc_i(6'h0D, ra, rw, 16'($urandom));
      endcase
    end
    image[L] = HALT;
  endtask

  initial begin
    gen_directed();
    build_model();
    abort_test();
    run_program("dir");
    check("dir_add",    mem[DBASE + 0],  32'h11);
    check("dir_sub",    mem[DBASE + 1],  32'h7);
    check("dir_and",    mem[DBASE + 2],  32'h4);
    check("dir_or",     mem[DBASE + 3],  32'hD);
    check("dir_slt",    mem[DBASE + 4],  32'h0);
    check("dir_lw",     mem[DBASE + 5],  32'h4);
    check("dir_r0",     mem[DBASE + 6],  32'h0);
    check("dir_neg",    mem[DBASE + 7],  32'hFFFF_FFFF);
    check("dir_skip",   mem[DBASE + 8],  32'hA5A5_0000 + 32'(DBASE + 8));
    check("dir_fall",   mem[DBASE + 9],  32'd12);
    check("dir_jump",   mem[DBASE + 10], 32'hABCD);
    check("dir_jskip",  mem[DBASE + 11], 32'hA5A5_0000 + 32'(DBASE + 11));
    check("dir_nop",    mem[DBASE + 12], 32'd5);
    for (int p = 0; p < 4; p++) begin
      gen_random(40);
      build_model();
      run_program($sformatf("rnd%0d", p));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
